// File: rtl/wishbone_pkg.sv
// Shared Wishbone crossbar types.
// Arbiter FSM states live here so every crossbar block agrees on the encoding.
package wishbone_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      OWNED = 2'd1,
      ABORT = 2'd2
   } arb_state_t;

endpackage

// File: rtl/wishbone_target_arbiter_if.sv
// Bundle of every initiator-side and target-side Wishbone signal around one target arbiter.
// The arbiter uses the slave view; whatever drives the initiators and models the target uses the master view.
interface wishbone_target_arbiter_if #(
   parameter int Initiators   = 2,
   parameter int AddressWidth = 16,
   parameter int DataWidth    = 8,
   parameter int SelWidth     = 1
);
   logic [Initiators-1:0][AddressWidth-1:0] I_ADR_O;
   logic [Initiators-1:0][DataWidth-1:0]    I_DAT_O;
   logic [Initiators-1:0][SelWidth-1:0]     I_SEL_O;
   logic [Initiators-1:0]                   I_WE_O;
   logic [Initiators-1:0]                   I_STB_O;
   logic [Initiators-1:0]                   I_CYC_O;
   logic [Initiators-1:0]                   I_LOCK_O;
   logic [DataWidth-1:0]                    I_DAT_I;
   logic [Initiators-1:0]                   I_ACK_I;
   logic [Initiators-1:0]                   I_ERR_I;
   logic [Initiators-1:0]                   I_RTY_I;
   logic [Initiators-1:0]                   I_STALL_I;

   logic [AddressWidth-1:0]                 T_ADR_O;
   logic [DataWidth-1:0]                    T_DAT_O;
   logic [SelWidth-1:0]                     T_SEL_O;
   logic                                    T_WE_O;
   logic                                    T_STB_O;
   logic                                    T_CYC_O;
   logic                                    T_LOCK_O;
   logic [DataWidth-1:0]                    T_DAT_I;
   logic                                    T_ACK_I;
   logic                                    T_ERR_I;
   logic                                    T_RTY_I;
   logic                                    T_STALL_I;

   logic [Initiators-1:0]                   GNT;

   modport slave (
      input  I_ADR_O, I_DAT_O, I_SEL_O, I_WE_O, I_STB_O, I_CYC_O, I_LOCK_O,
      input  T_DAT_I, T_ACK_I, T_ERR_I, T_RTY_I, T_STALL_I,
      output I_DAT_I, I_ACK_I, I_ERR_I, I_RTY_I, I_STALL_I,
      output T_ADR_O, T_DAT_O, T_SEL_O, T_WE_O, T_STB_O, T_CYC_O, T_LOCK_O,
      output GNT
   );

   modport master (
      output I_ADR_O, I_DAT_O, I_SEL_O, I_WE_O, I_STB_O, I_CYC_O, I_LOCK_O,
      output T_DAT_I, T_ACK_I, T_ERR_I, T_RTY_I, T_STALL_I,
      input  I_DAT_I, I_ACK_I, I_ERR_I, I_RTY_I, I_STALL_I,
      input  T_ADR_O, T_DAT_O, T_SEL_O, T_WE_O, T_STB_O, T_CYC_O, T_LOCK_O,
      input  GNT
   );

endinterface

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first eligible requester at or after ptr, in circular order.
// Rotate the request vector so ptr lands on bit 0, isolate the lowest set bit, rotate back.
module rr_pick #(
   parameter int N  = 2,
   parameter int PW = (N > 1) ? $clog2(N) : 1
) (
   input  logic [N-1:0]  req,
   input  logic [PW-1:0] ptr,
   input  logic [N-1:0]  exclude,
   output logic [N-1:0]  gnt,
   output logic          any
);

   logic [N-1:0] w_elig;
   logic [N-1:0] w_rot;
   logic [N-1:0] w_first;

   assign w_elig  = req & ~exclude;
   assign w_rot   = N'({w_elig, w_elig} >> ptr);
   assign w_first = w_rot & (-w_rot);
   assign gnt     = N'(({w_first, w_first} << ptr) >> N);
   assign any     = |w_elig;

endmodule

// File: rtl/wishbone_target_arbiter.sv
// Per-target Wishbone arbiter: round-robin grant held for a whole CYC/LOCK tenure,
// owner-only request mux and response routing, optional watchdog that aborts a hung cycle with ERR.
module wishbone_target_arbiter
   import wishbone_pkg::*;
#(
   parameter int Initiators    = 2,
   parameter int AddressWidth  = 16,
   parameter int DataWidth     = 8,
   parameter int SelWidth      = 1,
   parameter int TimeoutCycles = 0
) (
   input  logic                     CLK_I,
   input  logic                     RST_I,
   wishbone_target_arbiter_if.slave bus
);

   localparam int PW = (Initiators > 1) ? $clog2(Initiators) : 1;
   localparam int WW = (TimeoutCycles > 0) ? $clog2(TimeoutCycles + 1) : 1;
   localparam int RW = AddressWidth + DataWidth + SelWidth + 2;

   arb_state_t            r_state, w_state_next;
   logic [Initiators-1:0] r_gnt, w_gnt_next;
   logic [PW-1:0]         r_rr_ptr, w_rr_ptr_next;
   logic [WW-1:0]         r_wd, w_wd_next;

   logic [Initiators:0][RW-1:0] w_req_acc;
   logic [Initiators:0][PW-1:0] w_idx_acc;
   logic [RW-1:0]         w_own_req;
   logic [PW-1:0]         w_own_idx;
   logic [PW-1:0]         w_ptr_after;
   logic [PW-1:0]         w_pick_ptr;
   logic [Initiators-1:0] w_pick_excl;
   logic [Initiators-1:0] w_pick_gnt;
   logic                  w_pick_any;
   logic                  w_own_cyc;
   logic                  w_own_lock;
   logic                  w_owned;
   logic                  w_release;
   logic                  w_resp;
   logic                  w_timeout;

   // The grant is kept one-hot, so the owner mux is a plain AND-OR chain.
   assign w_req_acc[0] = '0;
   assign w_idx_acc[0] = '0;

   generate
      for (genvar gi = 0; gi < Initiators; gi++) begin : g_init
         assign w_req_acc[gi+1] = w_req_acc[gi] |
            ({bus.I_ADR_O[gi], bus.I_DAT_O[gi], bus.I_SEL_O[gi], bus.I_WE_O[gi], bus.I_STB_O[gi]}
             & {RW{r_gnt[gi]}});
         assign w_idx_acc[gi+1] = w_idx_acc[gi] | (r_gnt[gi] ? PW'(gi) : '0);

         assign bus.I_ACK_I[gi]   = w_owned & r_gnt[gi] & bus.T_ACK_I;
         assign bus.I_ERR_I[gi]   = w_owned & r_gnt[gi] & (bus.T_ERR_I | w_timeout);
         assign bus.I_RTY_I[gi]   = w_owned & r_gnt[gi] & bus.T_RTY_I;
         assign bus.I_STALL_I[gi] = ~(w_owned & r_gnt[gi]) | bus.T_STALL_I;
      end
   endgenerate

   assign w_own_req  = w_req_acc[Initiators];
   assign w_own_idx  = w_idx_acc[Initiators];
   assign w_own_cyc  = |(bus.I_CYC_O & r_gnt);
   assign w_own_lock = |(bus.I_LOCK_O & r_gnt);
   assign w_owned    = (r_state == OWNED);
   assign w_release  = (r_state != IDLE) && !w_own_cyc && !w_own_lock;
   assign w_resp     = bus.T_ACK_I | bus.T_ERR_I | bus.T_RTY_I;

   // A target response in the limit cycle wins over the timeout.
   assign w_timeout  = (TimeoutCycles > 0) && w_owned && w_own_cyc && !w_resp &&
                       (r_wd == WW'(TimeoutCycles));

   assign w_ptr_after = (w_own_idx == PW'(Initiators - 1)) ? '0 : w_own_idx + 1'b1;
   assign w_pick_ptr  = (r_state == IDLE) ? r_rr_ptr : w_ptr_after;
   assign w_pick_excl = (r_state == IDLE) ? '0 : r_gnt;

   rr_pick #(
      .N  (Initiators),
      .PW (PW)
   ) u_pick (
      .req     (bus.I_CYC_O),
      .ptr     (w_pick_ptr),
      .exclude (w_pick_excl),
      .gnt     (w_pick_gnt),
      .any     (w_pick_any)
   );

   always_ff @(posedge CLK_I) begin
      if (RST_I) begin
         r_state  <= IDLE;
         r_gnt    <= '0;
         r_rr_ptr <= '0;
         r_wd     <= '0;
      end else begin
         r_state  <= w_state_next;
         r_gnt    <= w_gnt_next;
         r_rr_ptr <= w_rr_ptr_next;
         r_wd     <= w_wd_next;
      end
   end

   always_comb begin
      w_state_next  = r_state;
      w_gnt_next    = r_gnt;
      w_rr_ptr_next = r_rr_ptr;
      w_wd_next     = r_wd;
      case (r_state)
         IDLE: begin
            if (w_pick_any) begin
               w_state_next = OWNED;
               w_gnt_next   = w_pick_gnt;
               w_wd_next    = '0;
            end
         end
         OWNED, ABORT: begin
            if (w_release) begin
               // Hand straight over to the next waiter; otherwise fall back to IDLE.
               w_rr_ptr_next = w_ptr_after;
               w_wd_next     = '0;
               if (w_pick_any) begin
                  w_state_next = OWNED;
                  w_gnt_next   = w_pick_gnt;
               end else begin
                  w_state_next = IDLE;
                  w_gnt_next   = '0;
               end
            end else if (r_state == OWNED) begin
               if (w_timeout) begin
                  w_state_next = ABORT;
               end
               if (TimeoutCycles > 0) begin
                  if (w_resp) begin
                     w_wd_next = '0;
                  end else if (w_own_cyc && !(&r_wd)) begin
                     w_wd_next = r_wd + 1'b1;
                  end
               end
            end
         end
         default: begin
            w_state_next = IDLE;
            w_gnt_next   = '0;
         end
      endcase
   end

   // Request signals reach the target only while OWNED, gated by the owner's CYC; LOCK passes alone.
   assign {bus.T_ADR_O, bus.T_DAT_O, bus.T_SEL_O, bus.T_WE_O, bus.T_STB_O} =
      w_owned ? (w_own_req & {RW{w_own_cyc}}) : '0;
   assign bus.T_CYC_O  = w_owned & w_own_cyc;
   assign bus.T_LOCK_O = w_owned & w_own_lock;
   assign bus.I_DAT_I  = w_owned ? bus.T_DAT_I : '0;
   assign bus.GNT      = r_gnt;

endmodule
